// File: rtl/adc_capture_pkg.sv
// Shared types and trigger-mode encodings for the ADC capture controller.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] MODE_IMM  = 2'd0;
    localparam logic [1:0] MODE_EXT  = 2'd1;
    localparam logic [1:0] MODE_RISE = 2'd2;
    localparam logic [1:0] MODE_FALL = 2'd3;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger qualifier: selects one channel, remembers the previous sample and
// produces a single-cycle trigger on a valid sample according to the mode.
module adc_trig_detect
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int CH_W     = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [CH_W-1:0]            trig_ch,
    input  logic [SAMPLE_W-1:0]        threshold,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       adc_valid,
    input  logic                       ext_trig,
    output logic                       trig
);

    logic [NUM_CH-1:0][SAMPLE_W-1:0] ch;
    logic signed [SAMPLE_W-1:0]      cur, prev, thr;
    logic                            prev_vld, hit;

    assign ch  = adc_data;
    assign thr = threshold;

    // Out-of-range channel selects fall back to channel 0
    always_comb begin
        cur = ch[0];
        for (int i = 1; i < NUM_CH; i++)
            if (trig_ch == CH_W'(i)) cur = ch[i];
    end

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_IMM:  hit = 1'b1;
            MODE_EXT:  hit = ext_trig;
            MODE_RISE: hit = prev_vld && (prev < thr) && (cur >= thr);
            default:   hit = prev_vld && (prev >= thr) && (cur < thr);
        endcase
    end

    assign trig = en && adc_valid && hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (clear) begin
            prev_vld <= 1'b0;
        end else if (en && adc_valid) begin
            prev     <= cur;
            prev_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Armed/triggered capture of a programmable number of decimated ADC samples
// into the capture FIFO, with sticky done/overflow status.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int LEN_W    = 24,
    parameter int DEC_W    = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 cfg_mode,
    input  logic [CH_W-1:0]            cfg_trig_ch,
    input  logic [SAMPLE_W-1:0]        cfg_threshold,
    input  logic [LEN_W-1:0]           cfg_length,
    input  logic [DEC_W-1:0]           cfg_decim,
    input  logic                       ext_trig,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       adc_valid,
    input  logic                       adc_ready,
    input  logic                       fifo_prog_full,
    input  logic                       fifo_busy,
    output logic [NUM_CH*SAMPLE_W-1:0] fifo_din,
    output logic                       fifo_wr_en,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [LEN_W-1:0]           sample_count
);

    state_t              state, state_nxt;
    logic [1:0]          mode_q;
    logic [CH_W-1:0]     ch_q;
    logic [SAMPLE_W-1:0] thr_q;
    logic [LEN_W-1:0]    len_q;
    logic [DEC_W-1:0]    decim_q, dcnt;
    logic                arm_ok, start, trig, fifo_block;
    logic                take, adv, wr, last, set_done, set_ovf;

    assign arm_ok     = arm && adc_ready && !fifo_busy && !abort;
    assign fifo_block = fifo_prog_full || fifo_busy;

    adc_trig_detect #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .CH_W     (CH_W)
    ) u_trig (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start),
        .en        (state == ST_ARMED),
        .mode      (mode_q),
        .trig_ch   (ch_q),
        .threshold (thr_q),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .ext_trig  (ext_trig),
        .trig      (trig)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        set_done  = 1'b0;
        set_ovf   = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (arm_ok) state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (!adc_ready) begin
                        state_nxt = ST_IDLE;
                        set_ovf   = 1'b1;
                    end else if (last) begin
                        state_nxt = ST_DONE;
                        set_done  = 1'b1;
                    end else if (trig) begin
                        state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!adc_ready) begin
                        state_nxt = ST_IDLE;
                        set_ovf   = 1'b1;
                    end else if (fifo_block) begin
                        state_nxt = ST_DONE;
                        set_ovf   = 1'b1;
                    end else if (last) begin
                        state_nxt = ST_DONE;
                        set_done  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // The triggering sample is the first one written, so it also advances decimation
    always_comb begin
        busy  = (state == ST_ARMED) || (state == ST_CAPTURE);
        start = arm_ok && ((state == ST_IDLE) || (state == ST_DONE));
        take  = 1'b0;
        adv   = 1'b0;
        case (state)
            ST_ARMED: begin
                take = trig;
                adv  = trig;
            end
            ST_CAPTURE: begin
                take = adc_valid && (dcnt == '0);
                adv  = adc_valid;
            end
            default: ;
        endcase
        wr   = take && !fifo_block && !abort && adc_ready;
        last = wr && (len_q != '0) && ((sample_count + 1'b1) == len_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_din     <= '0;
            fifo_wr_en   <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            sample_count <= '0;
            dcnt         <= '0;
            mode_q       <= MODE_IMM;
            ch_q         <= '0;
            thr_q        <= '0;
            len_q        <= '0;
            decim_q      <= '0;
        end else begin
            fifo_wr_en <= wr;
            if (wr) fifo_din <= adc_data;
            if (start) begin
                mode_q       <= cfg_mode;
                ch_q         <= cfg_trig_ch;
                thr_q        <= cfg_threshold;
                len_q        <= cfg_length;
                decim_q      <= cfg_decim;
                done         <= 1'b0;
                overflow     <= 1'b0;
                sample_count <= '0;
                dcnt         <= '0;
            end else begin
                if (set_done) done <= 1'b1;
                if (set_ovf)  overflow <= 1'b1;
                if (wr && !(&sample_count)) sample_count <= sample_count + 1'b1;
                if (adv) dcnt <= (dcnt == decim_q) ? '0 : dcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: table of capture scenarios with a
// write scoreboard, plus hand sequences for abort, ready loss and async reset.
module tb_adc_capture_ctrl;

    logic        clk, reset_n, arm, abort, ext_trig, adc_valid, adc_ready;
    logic        fifo_prog_full, fifo_busy, fifo_wr_en, busy, done, overflow;
    logic [1:0]  cfg_mode;
    logic [0:0]  cfg_trig_ch;
    logic [15:0] cfg_threshold;
    logic [23:0] cfg_length, sample_count;
    logic [7:0]  cfg_decim;
    logic [31:0] adc_data, fifo_din;

    adc_capture_ctrl #(.NUM_CH(2), .SAMPLE_W(16), .LEN_W(24), .DEC_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_trig_ch(cfg_trig_ch), .cfg_threshold(cfg_threshold),
        .cfg_length(cfg_length), .cfg_decim(cfg_decim), .ext_trig(ext_trig),
        .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
        .fifo_prog_full(fifo_prog_full), .fifo_busy(fifo_busy),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done),
        .overflow(overflow), .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mode, ch, thr, len, decim, start, dir, nsamp;
        int t, ext_at, pf_at, exp_wr, exp_done, exp_ovf;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] q[$];
    int          n_checks = 0, n_fail = 0, nwr = 0;
    bit          sb_en = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && reset_n && fifo_wr_en) begin
            nwr++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h expected no write", fifo_din);
            end else begin
                chk("fifo_din", fifo_din, q.pop_front());
            end
        end
    end

    // Entered and left at posedge+1. Pushes each sample the capture should write.
    task automatic run_vec(input vec_t v);
        int          nw = 0;
        bit          blocked = 1'b0;
        logic [15:0] c0, c1;
        cfg_mode      = 2'(v.mode);
        cfg_trig_ch   = 1'(v.ch);
        cfg_threshold = 16'(v.thr);
        cfg_length    = 24'(v.len);
        cfg_decim     = 8'(v.decim);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
        for (int k = 0; k < v.nsamp; k++) begin
            c0       = 16'(k);
            c1       = 16'(v.start + v.dir * k);
            adc_data = {c1, c0};
            ext_trig = (k == v.ext_at);
            if (!blocked && k >= v.t && ((k - v.t) % (v.decim + 1)) == 0 &&
                (v.len == 0 || nw < v.len)) begin
                if (nw == v.pf_at) begin
                    blocked        = 1'b1;
                    fifo_prog_full = 1'b1;
                end else begin
                    q.push_back({c1, c0});
                    nw++;
                end
            end
            adc_valid = 1'b1;
            @(posedge clk); #1;
        end
        adc_valid      = 1'b0;
        ext_trig       = 1'b0;
        fifo_prog_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        vec_t vr;
        //          mode ch thr  len dec start dir ns  t  ext pf  wr dn ov
        vecs[0] = '{0, 1, 0,   8,  0, 0,   1,  12, 0, -1, -1, 8, 1, 0};
        vecs[1] = '{2, 1, 100, 4,  0, 90,  1,  20, 10, -1, -1, 4, 1, 0};
        vecs[2] = '{3, 1, 100, 4,  0, 110, -1, 20, 11, -1, -1, 4, 1, 0};
        vecs[3] = '{0, 1, 0,   4,  2, 0,   1,  14, 0, -1, -1, 4, 1, 0};
        vecs[4] = '{0, 1, 0,   10, 0, 0,   1,  12, 0, -1, 2,  2, 0, 1};
        vecs[5] = '{1, 1, 0,   3,  0, 0,   1,  12, 5, 5,  -1, 3, 1, 0};
        vecs[6] = '{2, 0, 3,   3,  1, 0,   1,  12, 3, -1, -1, 3, 1, 0};
        vecs[7] = '{2, 1, 0,   2,  0, -5,  1,  12, 5, -1, -1, 2, 1, 0};
        vecs[8] = '{0, 1, 0,   1,  0, 0,   1,  4,  0, -1, -1, 1, 1, 0};

        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; ext_trig = 1'b0;
        adc_valid = 1'b0; adc_ready = 1'b1; fifo_prog_full = 1'b0; fifo_busy = 1'b0;
        cfg_mode = '0; cfg_trig_ch = '0; cfg_threshold = '0; cfg_length = '0;
        cfg_decim = '0; adc_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", sample_count, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            w0 = nwr;
            run_vec(vecs[i]);
            chk($sformatf("v%0d_writes", i), nwr - w0, vecs[i].exp_wr);
            chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
            chk($sformatf("v%0d_count", i), sample_count, vecs[i].exp_wr);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_sb_empty", i), q.size(), 0);
        end

        // abort coincident with external trigger while armed
        w0 = nwr;
        cfg_mode = 2'd1; cfg_length = 24'd4; cfg_decim = '0;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("abort_armed_busy", busy, 1);
        adc_valid = 1'b1; ext_trig = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        adc_valid = 1'b0; ext_trig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_writes", nwr - w0, 0);

        // adc_ready loss during continuous capture
        vr = '{0, 1, 0, 0, 0, 0, 1, 3, 0, -1, -1, 3, 0, 0};
        w0 = nwr;
        run_vec(vr);
        chk("cont_writes", nwr - w0, 3);
        chk("cont_busy", busy, 1);
        adc_ready = 1'b0;
        @(posedge clk); #1;
        adc_ready = 1'b1;
        chk("rdy_ovf", overflow, 1);
        chk("rdy_done", done, 0);
        chk("rdy_busy", busy, 0);

        // arm refused when not ready or fifo busy
        adc_ready = 1'b0; arm = 1'b1;
        @(posedge clk); #1;
        adc_ready = 1'b1; fifo_busy = 1'b1;
        chk("arm_notready_busy", busy, 0);
        @(posedge clk); #1;
        arm = 1'b0; fifo_busy = 1'b0;
        chk("arm_fifobusy_busy", busy, 0);

        // asynchronous reset in the middle of a capture
        sb_en = 1'b0;
        cfg_mode = 2'd0; cfg_length = '0;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0; adc_valid = 1'b1; adc_data = 32'h0002_0001;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_wr_en", fifo_wr_en, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_wr_en", fifo_wr_en, 0);
        chk("arst_din", fifo_din, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", sample_count, 0);
        chk("arst_ovf", overflow, 0);
        adc_valid = 1'b0;
        q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
